// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding, load-use stall and bubble counting.
// Capture latency is one cycle; srcA/srcB/store data and stall are combinational.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [3:0]       alu_control_d,
  input  logic             alu_src_a_d,
  input  logic             alu_src_b_d,
  input  logic             reg_write_d,
  input  logic             mem_read_d,
  input  logic             mem_write_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic             flush_e,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_w,
  input  logic [XLEN-1:0]  result_w,
  output logic [XLEN-1:0]  src_a_e,
  output logic [XLEN-1:0]  src_b_e,
  output logic [XLEN-1:0]  write_data_e,
  output logic [3:0]       alu_control_e,
  output logic [4:0]       rd_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  imm_e,
  output logic             valid_e,
  output logic             reg_write_e,
  output logic             mem_read_e,
  output logic             mem_write_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             stall_d,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_control;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard;
  logic [XLEN-1:0]  fwd_a, fwd_b;

  // Conservative: both source fields are compared whatever the format.
  always_comb begin
    hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & valid_d &
             ((ex_q.rd == rs1_d) | (ex_q.rd == rs2_d));
  end

  assign stall_d = hazard & ~flush_e;

  always_comb begin
    ex_d = '0;
    if (!flush_e && !hazard) begin
      ex_d.valid       = valid_d;
      ex_d.rs1         = rs1_d;
      ex_d.rs2         = rs2_d;
      ex_d.rd          = rd_d;
      ex_d.rd1         = (reg_write_w && rd_w != 5'd0 && rd_w == rs1_d) ? result_w : rd1_d;
      ex_d.rd2         = (reg_write_w && rd_w != 5'd0 && rd_w == rs2_d) ? result_w : rd2_d;
      ex_d.imm         = imm_d;
      ex_d.pc          = pc_d;
      ex_d.alu_control = alu_control_d;
      ex_d.alu_src_a   = alu_src_a_d;
      ex_d.alu_src_b   = alu_src_b_d;
      ex_d.reg_write   = reg_write_d;
      ex_d.mem_read    = mem_read_d;
      ex_d.mem_write   = mem_write_d;
      ex_d.branch      = branch_d;
      ex_d.jump        = jump_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (stall_d && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // MEM result is younger than WB, so it wins; x0 never forwards.
  always_comb begin
    if (reg_write_m && rd_m != 5'd0 && rd_m == ex_q.rs1)      fwd_a = alu_result_m;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == ex_q.rs1) fwd_a = result_w;
    else                                                      fwd_a = ex_q.rd1;
    if (reg_write_m && rd_m != 5'd0 && rd_m == ex_q.rs2)      fwd_b = alu_result_m;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == ex_q.rs2) fwd_b = result_w;
    else                                                      fwd_b = ex_q.rd2;
  end

  assign src_a_e       = ex_q.alu_src_a ? ex_q.pc  : fwd_a;
  assign src_b_e       = ex_q.alu_src_b ? ex_q.imm : fwd_b;
  assign write_data_e  = fwd_b;
  assign alu_control_e = ex_q.alu_control;
  assign rd_e          = ex_q.rd;
  assign pc_e          = ex_q.pc;
  assign imm_e         = ex_q.imm;
  assign valid_e       = ex_q.valid;
  assign reg_write_e   = ex_q.reg_write;
  assign mem_read_e    = ex_q.mem_read;
  assign mem_write_e   = ex_q.mem_write;
  assign branch_e      = ex_q.branch;
  assign jump_e        = ex_q.jump;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage with a 2-bit bubble counter so saturation is reachable.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid_d, alu_src_a_d, alu_src_b_d, reg_write_d, mem_read_d, mem_write_d;
  logic branch_d, jump_d, flush_e, reg_write_m, reg_write_w;
  logic [4:0] rs1_d, rs2_d, rd_d, rd_m, rd_w;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d, pc_d, alu_result_m, result_w;
  logic [3:0] alu_control_d;
  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, pc_e, imm_e;
  logic [3:0] alu_control_e;
  logic [4:0] rd_e;
  logic valid_e, reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e, stall_d;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d), .alu_control_d(alu_control_d),
    .alu_src_a_d(alu_src_a_d), .alu_src_b_d(alu_src_b_d), .reg_write_d(reg_write_d),
    .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .branch_d(branch_d), .jump_d(jump_d),
    .flush_e(flush_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .alu_result_m(alu_result_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .result_w(result_w),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .write_data_e(write_data_e),
    .alu_control_e(alu_control_e), .rd_e(rd_e), .pc_e(pc_e), .imm_e(imm_e),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
    .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
    .stall_d(stall_d), .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic [31:0] a, b, wd;
    logic [4:0]  rd;
    logic        valid, rw, mr, stall;
    logic [1:0]  cnt;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp_o;
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] model_cnt = 2'd0;

  function automatic obs_t mk(input logic [31:0] a, b, wd, input logic [4:0] rd,
                              input logic v, rw, mr, st, input logic [1:0] c);
    mk = '{a: a, b: b, wd: wd, rd: rd, valid: v, rw: rw, mr: mr, stall: st, cnt: c};
  endfunction

  function automatic obs_t sample();
    sample = '{a: src_a_e, b: src_b_e, wd: write_data_e, rd: rd_e, valid: valid_e,
               rw: reg_write_e, mr: mem_read_e, stall: stall_d, cnt: bubble_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0; rd1_d = 0; rd2_d = 0; imm_d = 0; pc_d = 0;
    alu_control_d = 0; alu_src_a_d = 0; alu_src_b_d = 0; reg_write_d = 0; mem_read_d = 0;
    mem_write_d = 0; branch_d = 0; jump_d = 0; flush_e = 0;
  endtask

  task automatic idle_mw();
    rd_m = 0; reg_write_m = 0; alu_result_m = 0; rd_w = 0; reg_write_w = 0; result_w = 0;
  endtask

  task automatic load_lw(input logic [4:0] rd);
    clear_dec();
    valid_d = 1; rd_d = rd; mem_read_d = 1; reg_write_d = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    valid_d = 1; rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
    rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom; pc_d = $urandom;
    alu_control_d = 4'($urandom); alu_src_a_d = 1'($urandom); alu_src_b_d = 1'($urandom);
    reg_write_d = 1; mem_read_d = 1; mem_write_d = 1; branch_d = 1; jump_d = 1;
    flush_e = 1'($urandom); rd_m = 5'($urandom); reg_write_m = 1; alu_result_m = $urandom;
    rd_w = 5'($urandom); reg_write_w = 1; result_w = $urandom;
    tick(); tick();
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL reset_main got=%h exp=%h", got, exp_o); end
    n_cmp++;
    if ({pc_e, imm_e, alu_control_e, mem_write_e, branch_e, jump_e} !== '0) begin
      n_err++; $display("FAIL reset_fields got pc=%h imm=%h ctl=%h mw/br/j=%b%b%b exp all 0",
                        pc_e, imm_e, alu_control_e, mem_write_e, branch_e, jump_e);
    end
    rst = 0; clear_dec(); idle_mw(); model_cnt = 0;
  endtask

  task automatic test_basic_capture();
    clear_dec(); idle_mw();
    valid_d = 1; rs1_d = 1; rs2_d = 2; rd_d = 3; rd1_d = 5; rd2_d = 7; reg_write_d = 1;
    sb.push_back(mk(5, 7, 7, 3, 1, 1, 0, 0, model_cnt));
    tick(); clear_dec();
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL basic_capture got=%h exp=%h", got, exp_o); end
  endtask

  task automatic test_forward_priority();
    clear_dec(); idle_mw();
    valid_d = 1; rs1_d = 3; rd_d = 9; rd1_d = 32'h1234; reg_write_d = 1;
    tick(); clear_dec();
    rd_m = 3; alu_result_m = 32'h11; reg_write_m = 1; rd_w = 3; result_w = 32'h22; reg_write_w = 1;
    #1; sb.push_back(mk(32'h11, 0, 0, 9, 1, 1, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL fwd_mem_over_wb got=%h exp=%h", got, exp_o); end
    reg_write_m = 0;
    #1; sb.push_back(mk(32'h22, 0, 0, 9, 1, 1, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL fwd_wb got=%h exp=%h", got, exp_o); end
    idle_mw();
    valid_d = 1; rs1_d = 0; rs2_d = 6; rd_d = 10; rd1_d = 32'h55; rd2_d = 32'h1; reg_write_d = 1;
    tick(); clear_dec();
    rd_m = 0; reg_write_m = 1; alu_result_m = 32'hBAD; rd_w = 0; reg_write_w = 1; result_w = 32'hBAD;
    #1; sb.push_back(mk(32'h55, 32'h1, 32'h1, 10, 1, 1, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL fwd_x0_none got=%h exp=%h", got, exp_o); end
    rd_m = 6; alu_result_m = 32'h66;
    #1; sb.push_back(mk(32'h55, 32'h66, 32'h66, 10, 1, 1, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL fwd_rs2_mem got=%h exp=%h", got, exp_o); end
    idle_mw();
  endtask

  task automatic test_load_use();
    clear_dec(); idle_mw(); tick();
    load_lw(5); rs1_d = 1; rd1_d = 32'h100; alu_src_b_d = 1; imm_d = 4;
    tick(); clear_dec();
    valid_d = 1; rs1_d = 5; rs2_d = 1; rd_d = 6; rd2_d = 32'h10; reg_write_d = 1;
    #1; sb.push_back(mk(32'h100, 4, 0, 5, 1, 1, 1, 1, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL load_use_stall got=%h exp=%h", got, exp_o); end
    tick(); model_cnt = model_cnt + 2'd1;
    rd_m = 5; reg_write_m = 1; alu_result_m = 32'h104;
    #1; sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL load_use_bubble got=%h exp=%h", got, exp_o); end
    tick(); clear_dec();
    idle_mw(); rd_w = 5; reg_write_w = 1; result_w = 32'hDEAD;
    #1; sb.push_back(mk(32'hDEAD, 32'h10, 32'h10, 6, 1, 1, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL load_use_wb_fwd got=%h exp=%h", got, exp_o); end
    idle_mw();
  endtask

  task automatic test_flush_over_hazard();
    clear_dec(); idle_mw(); tick();
    load_lw(7);
    tick(); clear_dec();
    valid_d = 1; rs1_d = 7; rd_d = 8; reg_write_d = 1; flush_e = 1;
    #1; sb.push_back(mk(0, 0, 0, 7, 1, 1, 1, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL flush_stall_low got=%h exp=%h", got, exp_o); end
    tick(); clear_dec();
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL flush_bubble got=%h exp=%h", got, exp_o); end
  endtask

  task automatic test_imm_bypass();
    clear_dec(); idle_mw();
    valid_d = 1; rs2_d = 2; rd_d = 8; rd2_d = 32'h3333; reg_write_d = 1; alu_control_d = 4'd10;
    alu_src_b_d = 1; imm_d = 32'hABCDE000; alu_src_a_d = 1; pc_d = 32'h1000;
    tick(); clear_dec();
    rd_m = 2; reg_write_m = 1; alu_result_m = 32'h7777;
    #1; sb.push_back(mk(32'h1000, 32'hABCDE000, 32'h7777, 8, 1, 1, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL imm_pc_mux got=%h exp=%h", got, exp_o); end
    n_cmp++;
    if (alu_control_e !== 4'd10) begin
      n_err++; $display("FAIL alu_control got=%0d exp=10", alu_control_e);
    end
    idle_mw();
    valid_d = 1; rs1_d = 4; rs2_d = 4; rd_d = 11; reg_write_d = 1;
    rd_w = 4; reg_write_w = 1; result_w = 32'h99;
    tick(); clear_dec(); idle_mw();
    sb.push_back(mk(32'h99, 32'h99, 32'h99, 11, 1, 1, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL decode_bypass got=%h exp=%h", got, exp_o); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      clear_dec(); idle_mw(); tick();
      load_lw(5);
      tick(); clear_dec();
      valid_d = 1; rs2_d = 5; rd_d = 12; reg_write_d = 1;
      tick();
      if (model_cnt != 2'd3) model_cnt = model_cnt + 2'd1;
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, model_cnt));
      exp_o = sb.pop_front(); got = sample(); n_cmp++;
      if (got !== exp_o) begin
        n_err++; $display("FAIL saturate_%0d got=%h exp=%h", i, got, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_dec(); idle_mw(); tick();
    load_lw(9);
    tick(); clear_dec();
    valid_d = 1; rs1_d = 9; rd_d = 13; reg_write_d = 1; rst = 1;
    tick(); rst = 0; model_cnt = 0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, model_cnt));
    exp_o = sb.pop_front(); got = sample(); n_cmp++;
    if (got !== exp_o) begin n_err++; $display("FAIL reset_mid_stall got=%h exp=%h", got, exp_o); end
    clear_dec();
  endtask

  initial begin
    rst = 1; clear_dec(); idle_mw();
    #1;
    test_reset();
    test_basic_capture();
    test_forward_priority();
    test_load_use();
    test_flush_over_hazard();
    test_imm_bypass();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Execute-stage front end of the 5-stage RV32I pipeline. Registers decoded instructions from ID into EX and resolves EX-operand forwarding from MEM and WB. Drives the ALU's srcA, srcB and ALUControl inputs, plus the store data passed on to MEM. Also detects load-use hazards, inserts bubbles, honours branch flushes, and counts inserted load-use bubbles.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the bubble counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_d  in  1  decode slot holds a real instruction
- rs1_d, rs2_d, rd_d  in  5 each  register indices
- rd1_d, rd2_d  in  XLEN each  register-file read data
- imm_d, pc_d  in  XLEN each  immediate and PC
- alu_control_d  in  4  ALU opcode (ADD=0 … LUI=10)
- alu_src_a_d  in  1  1 = srcA takes PC
- alu_src_b_d  in  1  1 = srcB takes immediate
- reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d  in  1 each  control bits
- flush_e  in  1  taken branch/jump resolved in EX; squash decode slot
- rd_m  in  5  MEM-stage destination register
- reg_write_m  in  1  MEM-stage register-write enable
- alu_result_m  in  XLEN  MEM-stage ALU result
- rd_w  in  5  WB-stage destination register
- reg_write_w  in  1  WB-stage register-write enable
- result_w  in  XLEN  WB-stage result
- src_a_e, src_b_e  out  XLEN each  ALU operands
- write_data_e  out  XLEN  forwarded rs2 value (store data)
- alu_control_e  out  4  registered opcode
- rd_e, pc_e, imm_e  out  registered fields
- valid_e, reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e  out  1 each  registered control
- stall_d  out  1  freeze PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles

## Operation
- **Register update, one action per rising edge, priority order:**
  - rst: clear all.
  - flush_e: load bubble.
  - hazard: load bubble.
  - otherwise: capture the decode fields.
- **Bubble:** every registered field is zero, data included.
- **Hazard (combinational):**
  - hazard = valid_e & mem_read_e & (rd_e≠0) & valid_d & (rd_e==rs1_d | rd_e==rs2_d).
  - Both source registers are compared regardless of instruction format (conservative).
- **stall_d** = hazard & ~flush_e.
- **Decode-side bypass at capture:** if reg_write_w & rd_w≠0 & rd_w==rs1_d, register result_w instead of rd1_d. rs2 is handled the same way.
- **EX forwarding, per operand (rs1_e → fwd_a, rs2_e → fwd_b):**
  - MEM hit (reg_write_m & rd_m≠0 & rd_m==rs): alu_result_m.
  - Else WB hit (same test on rd_w / reg_write_w): result_w.
  - Else the registered read data.
  - MEM has priority over WB; x0 is never forwarded.
- **ALU operands and store data:**
  - src_a_e = alu_src_a_e ? pc_e : fwd_a.
  - src_b_e = alu_src_b_e ? imm_e : fwd_b.
  - write_data_e = fwd_b always, even when alu_src_b_e=1.
- **bubble_cnt:**
  - Increments by 1 on each edge where a hazard bubble is loaded (hazard & ~flush_e & ~rst).
  - Saturates at all-ones; cleared only by rst.
  - Flush bubbles are not counted.

## Timing
- **Reset:** all registered outputs 0 and bubble_cnt = 0 on the edge after rst=1. Consequently valid_e=0, stall_d=0, src_a_e = src_b_e = 0.
- **Latency:** an instruction captured at edge N is presented in EX during cycle N..N+1.
- **Combinational paths:** src_a_e, src_b_e and write_data_e are combinational from EX registers plus the MEM/WB inputs. stall_d is combinational from EX registers plus the decode inputs.
- **Load-use:** the load is in EX, the dependent instruction is in ID.
  - stall_d=1 for one cycle; a bubble enters EX.
  - The next cycle the load is in MEM (rd_m), so no hazard; the dependent instruction is captured.
  - It later receives load data via WB forwarding (one-cycle penalty).
- **Flush and hazard together:** the flush wins, stall_d=0, bubble_cnt is unchanged.
- **Reset mid-stall:** rst overrides; stall_d drops on the following cycle.

## Test plan
- **Reset:** rst=1 for 2 cycles with random inputs → all outputs 0, bubble_cnt=0.
- **Basic capture:** capture `add x3,x1,x2` with rd1_d=5, rd2_d=7, ADD, no hazards → next cycle src_a_e=5, src_b_e=7, rd_e=3, reg_write_e=1.
- **Forward priority:**
  - rs1_e=3, rd_m=3 (alu_result_m=0x11), rd_w=3 (result_w=0x22), both write enables 1 → src_a_e=0x11.
  - Drop reg_write_m → src_a_e=0x22.
  - Set rs1_e=0, rd_m=0 → no forwarding.
- **Load-use:** `lw x5` in EX and `add x6,x5,x1` in ID → stall_d=1 for exactly one cycle, bubble in EX (valid_e=0), bubble_cnt=1. The add then enters EX with src_a_e=result_w (load data) via WB forward.
- **Flush over hazard:** flush_e=1 while the load-use condition holds → stall_d=0, next-cycle valid_e=0, reg_write_e=0, bubble_cnt unchanged.
- **Immediate/PC mux, bypass, saturation:**
  - alu_src_b_d=1, imm_d=0xABCDE000, LUI → src_b_e=0xABCDE000 while write_data_e still shows forwarded rs2.
  - Capture with rd_w==rs1_d=4, result_w=0x99 → src_a_e=0x99.
  - CNT_W=2 with 5 hazards → bubble_cnt=3.
